// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids and the
// width helper for the read-latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_F    = 2'd1,
    ID_D    = 2'd2,
    ID_S    = 2'd3
  } id_e;

  // The counter runs 0..lat-1, so it never needs more than clog2(lat) bits.
  function automatic int lat_cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the memory port arbiter.
// slave = the arbiter itself; master = requesters plus the memory array.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Handshake: a requester raises *_req with stable fields and holds them until
  // its *_done pulses for one cycle; req still high in the following IDLE cycle
  // is a fresh request. rd_data is valid only in the cycle of a read's done.
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;

  logic          s_req;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_done;

  logic [DW-1:0] rd_data;
  logic          busy;
  logic [1:0]    gnt_id;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
           s_req, s_we, s_addr, s_wdata, mem_rdata,
    output f_done, d_done, s_done, rd_data, busy, gnt_id,
           mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
           s_req, s_we, s_addr, s_wdata, mem_rdata,
    input  f_done, d_done, s_done, rd_data, busy, gnt_id,
           mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select among fetch, load/store and stack requesters.
// MEM_ARB_RR_EN: round-robin after last_i; otherwise fixed priority S > D > F.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic f_req_i,
  input  logic d_req_i,
  input  logic s_req_i,
  input  id_e  last_i,
  output id_e  win_o
);

`ifdef MEM_ARB_RR_EN
  // Search starts at the requester after the last owner, cyclic F -> D -> S.
  always_comb begin
    win_o = ID_NONE;
    case (last_i)
      ID_D: begin
        if      (s_req_i) win_o = ID_S;
        else if (f_req_i) win_o = ID_F;
        else if (d_req_i) win_o = ID_D;
      end
      ID_S: begin
        if      (f_req_i) win_o = ID_F;
        else if (d_req_i) win_o = ID_D;
        else if (s_req_i) win_o = ID_S;
      end
      default: begin
        if      (d_req_i) win_o = ID_D;
        else if (s_req_i) win_o = ID_S;
        else if (f_req_i) win_o = ID_F;
      end
    endcase
  end
`else
  logic unused_last;
  assign unused_last = ^last_i;

  always_comb begin
    win_o = ID_NONE;
    if      (s_req_i) win_o = ID_S;
    else if (d_req_i) win_o = ID_D;
    else if (f_req_i) win_o = ID_F;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch, load/store and stack accesses onto one memory port with
// registered outputs. MEM_ARB_RR_EN selects round-robin instead of S > D > F.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_b,
  mem_port_arbiter_if.slave   bus,
  output state_e              dbg_state_o
);

  localparam int CW = lat_cnt_w(MEM_LAT);

  state_e        state_q, state_d;
  id_e           owner_q, owner_d;
  id_e           pick;
  id_e           last;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          f_done_q, f_done_d;
  logic          d_done_q, d_done_d;
  logic          s_done_q, s_done_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          busy_q, busy_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;

`ifdef MEM_ARB_RR_EN
  id_e ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick != ID_NONE) ptr_d = pick;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ptr_q <= ID_F;
    else        ptr_q <= ptr_d;
  end

  assign last = ptr_q;
`else
  assign last = ID_F;
`endif

  mem_arb_pick u_pick (
    .f_req_i (bus.f_req),
    .d_req_i (bus.d_req),
    .s_req_i (bus.s_req),
    .last_i  (last),
    .win_o   (pick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick != ID_NONE) begin
          state_d = ISSUE;
          owner_d = pick;
          case (pick)
            ID_F: begin
              we_d    = 1'b0;
              addr_d  = bus.f_addr;
              wdata_d = '0;
            end
            ID_D: begin
              we_d    = bus.d_we;
              addr_d  = bus.d_addr;
              wdata_d = bus.d_wdata;
            end
            default: begin
              we_d    = bus.s_we;
              addr_d  = bus.s_addr;
              wdata_d = bus.s_wdata;
            end
          endcase
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (we_q) state_d = RESP;
        else      state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(MEM_LAT - 1)) state_d = RESP;
        else                           cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes from a flop.
  always_comb begin
    mem_re_d    = (state_d == ISSUE) && !we_d;
    mem_we_d    = (state_d == ISSUE) && we_d;
    mem_addr_d  = (state_d == ISSUE) ? addr_d : '0;
    mem_wdata_d = (state_d == ISSUE && we_d) ? wdata_d : '0;
    f_done_d    = (state_d == RESP) && (owner_d == ID_F);
    d_done_d    = (state_d == RESP) && (owner_d == ID_D);
    s_done_d    = (state_d == RESP) && (owner_d == ID_S);
    rd_data_d   = (state_d == RESP && state_q == WAIT) ? bus.mem_rdata : '0;
    busy_d      = (state_d != IDLE);
    gnt_d       = 2'd0;
    if (busy_d) gnt_d = owner_d;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      owner_q     <= ID_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      s_done_q    <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      gnt_q       <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      s_done_q    <= s_done_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign bus.f_done    = f_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.s_done    = s_done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;
  assign bus.gnt_id    = gnt_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1 (scoreboarded) and one
// with MEM_LAT=3 for latency and mid-read reset; honours MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(16), .DW(16)) b1 ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) b3 ();
  state_e st1, st3;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .bus(b1.slave), .dbg_state_o(st1)
  );
  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .bus(b3.slave), .dbg_state_o(st3)
  );

  // ---------------- memory models ----------------
  logic [15:0] mem [0:65535];
  logic [15:0] p1, p3a, p3b, p3c;
  always @(posedge clk) begin
    p1  <= b1.mem_re ? mem[b1.mem_addr] : 16'h0;
    p3a <= b3.mem_re ? mem[b3.mem_addr] : 16'h0;
    p3b <= p3a;
    p3c <= p3b;
    if (b1.mem_we) mem[b1.mem_addr] = b1.mem_wdata;
  end
  assign b1.mem_rdata = p1;
  assign b3.mem_rdata = p3c;

  wire [55:0] all1 = {b1.f_done, b1.d_done, b1.s_done, b1.rd_data, b1.busy, b1.gnt_id,
                      b1.mem_addr, b1.mem_wdata, b1.mem_we, b1.mem_re};
  wire [55:0] all3 = {b3.f_done, b3.d_done, b3.s_done, b3.rd_data, b3.busy, b3.gnt_id,
                      b3.mem_addr, b3.mem_wdata, b3.mem_we, b3.mem_re};

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  // ---------------- scoreboard on the MEM_LAT=1 instance ----------------
  always @(negedge clk) begin
    logic [2:0]  dn;
    logic [1:0]  id_act;
    logic [17:0] e;
    dn = {b1.s_done, b1.d_done, b1.f_done};
    if (rst_b === 1'b1 && dn != 3'b000) begin
      checks++;
      id_act = dn[0] ? 2'd1 : (dn[1] ? 2'd2 : 2'd3);
      if ($countones(dn) != 1) begin
        errors++;
        $display("FAIL done_overlap dones=%b required one-hot", dn);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done id=%0d rd_data=%h required no done", id_act, b1.rd_data);
      end else begin
        e = exp_q.pop_front();
        if ({id_act, b1.rd_data} !== e || b1.gnt_id !== e[17:16]) begin
          errors++;
          $display("FAIL sb_done id=%0d gnt=%0d rd_data=%h required id=%0d rd_data=%h",
                   id_act, b1.gnt_id, b1.rd_data, e[17:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_bus();
    b1.f_req = 0; b1.f_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b1.s_req = 0; b1.s_we = 0; b1.s_addr = 0; b1.s_wdata = 0;
    b3.f_req = 0; b3.f_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
    b3.s_req = 0; b3.s_we = 0; b3.s_addr = 0; b3.s_wdata = 0;
  endtask

  task automatic apply_reset();
    rst_b = 1'b0;
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
  endtask

  // Holds req on bus1 until n done pulses of that requester, then drops it.
  task automatic req_drive(input id_e id, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input int n);
    int got = 0;
    case (id)
      ID_F: begin b1.f_addr = addr; b1.f_req = 1'b1; end
      ID_D: begin b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata; b1.d_req = 1'b1; end
      default: begin b1.s_we = we; b1.s_addr = addr; b1.s_wdata = wdata; b1.s_req = 1'b1; end
    endcase
    for (int c = 0; c < 80 && got < n; c++) begin
      tick();
      case (id)
        ID_F:    if (b1.f_done) got++;
        ID_D:    if (b1.d_done) got++;
        default: if (b1.s_done) got++;
      endcase
    end
    case (id)
      ID_F:    b1.f_req = 1'b0;
      ID_D:    b1.d_req = 1'b0;
      default: b1.s_req = 1'b0;
    endcase
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL req_timeout id=%0d dones=%0d required %0d", id, got, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) tick();
    checks++;
    if (all1 !== 56'h0) begin errors++; $display("FAIL reset_out1 outs=%h required 0", all1); end
    checks++;
    if (all3 !== 56'h0) begin errors++; $display("FAIL reset_out3 outs=%h required 0", all3); end
    checks++;
    if (st1 !== IDLE || st3 !== IDLE) begin
      errors++; $display("FAIL reset_state st1=%0d st3=%0d required 0", st1, st3);
    end
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    exp_q.push_back({2'd1, 16'hBEEF});
    b1.f_addr = 16'h0010; b1.f_req = 1'b1;
    tick();
    checks++;
    if (b1.mem_re !== 1'b1 || b1.mem_we !== 1'b0 || b1.mem_addr !== 16'h0010) begin
      errors++; $display("FAIL fetch_c1 re=%b we=%b addr=%h required 1 0 0010",
                         b1.mem_re, b1.mem_we, b1.mem_addr);
    end
    checks++;
    if (b1.gnt_id !== 2'd1 || b1.busy !== 1'b1) begin
      errors++; $display("FAIL fetch_gnt_c1 gnt=%0d busy=%b required 1 1", b1.gnt_id, b1.busy);
    end
    tick();
    checks++;
    if (b1.mem_re !== 1'b0 || b1.f_done !== 1'b0 || b1.gnt_id !== 2'd1) begin
      errors++; $display("FAIL fetch_c2 re=%b done=%b gnt=%0d required 0 0 1",
                         b1.mem_re, b1.f_done, b1.gnt_id);
    end
    tick();
    checks++;
    if (b1.f_done !== 1'b1 || b1.rd_data !== 16'hBEEF || b1.gnt_id !== 2'd1) begin
      errors++; $display("FAIL fetch_c3 done=%b rd=%h gnt=%0d required 1 beef 1",
                         b1.f_done, b1.rd_data, b1.gnt_id);
    end
    b1.f_req = 1'b0;
    tick();
    checks++;
    if (b1.busy !== 1'b0 || b1.gnt_id !== 2'd0 || b1.f_done !== 1'b0 || b1.rd_data !== 16'h0) begin
      errors++; $display("FAIL fetch_c4 busy=%b gnt=%0d done=%b rd=%h required 0 0 0 0",
                         b1.busy, b1.gnt_id, b1.f_done, b1.rd_data);
    end
  endtask

  task automatic test_push_pop();
    exp_q.push_back({2'd3, 16'h0000});
    b1.s_we = 1'b1; b1.s_addr = 16'h00FF; b1.s_wdata = 16'h1234; b1.s_req = 1'b1;
    tick();
    checks++;
    if (b1.mem_we !== 1'b1 || b1.mem_re !== 1'b0 || b1.mem_addr !== 16'h00FF ||
        b1.mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL push_c1 we=%b re=%b addr=%h wdata=%h required 1 0 00ff 1234",
                         b1.mem_we, b1.mem_re, b1.mem_addr, b1.mem_wdata);
    end
    tick();
    checks++;
    if (b1.s_done !== 1'b1 || b1.mem_we !== 1'b0 || b1.gnt_id !== 2'd3) begin
      errors++; $display("FAIL push_c2 done=%b we=%b gnt=%0d required 1 0 3",
                         b1.s_done, b1.mem_we, b1.gnt_id);
    end
    b1.s_req = 1'b0;
    tick();
    exp_q.push_back({2'd3, 16'h1234});
    req_drive(ID_S, 1'b0, 16'h00FF, 16'h0, 1);
    tick();
  endtask

  task automatic test_field_change();
    exp_q.push_back({2'd2, 16'h5A5A});
    b1.d_we = 1'b0; b1.d_addr = 16'h0020; b1.d_req = 1'b1;
    tick();
    b1.d_addr = 16'h0030;
    checks++;
    if (b1.mem_addr !== 16'h0020 || b1.mem_re !== 1'b1) begin
      errors++; $display("FAIL field_c1 addr=%h re=%b required 0020 1", b1.mem_addr, b1.mem_re);
    end
    tick();
    tick();
    checks++;
    if (b1.d_done !== 1'b1 || b1.rd_data !== 16'h5A5A) begin
      errors++; $display("FAIL field_done done=%b rd=%h required 1 5a5a", b1.d_done, b1.rd_data);
    end
    b1.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic seen = 1'b0;
    b3.d_we = 1'b0; b3.d_addr = 16'h0040; b3.d_req = 1'b1;
    tick();
    checks++;
    if (b3.mem_re !== 1'b1 || b3.mem_addr !== 16'h0040) begin
      errors++; $display("FAIL midrst_c1 re=%b addr=%h required 1 0040", b3.mem_re, b3.mem_addr);
    end
    tick();
    rst_b = 1'b0;
    #1;
    checks++;
    if (all3 !== 56'h0) begin errors++; $display("FAIL midrst_out outs=%h required 0", all3); end
    checks++;
    if (st3 !== IDLE) begin errors++; $display("FAIL midrst_state st=%0d required 0", st3); end
    b3.d_req = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    repeat (8) begin
      tick();
      if (b3.d_done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_done seen=%b required 0", seen); end
    checks++;
    if (st3 !== IDLE || b3.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle st=%0d busy=%b required 0 0", st3, b3.busy);
    end
  endtask

  task automatic test_read_lat3();
    int dc = -1;
    logic [15:0] d = 16'h0;
    b3.d_we = 1'b0; b3.d_addr = 16'h0040; b3.d_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (b3.d_done === 1'b1 && dc < 0) begin
        dc = c;
        d = b3.rd_data;
        b3.d_req = 1'b0;
      end
    end
    b3.d_req = 1'b0;
    checks++;
    if (dc != 5) begin errors++; $display("FAIL lat3_cycle done_cycle=%0d required 5", dc); end
    checks++;
    if (d !== 16'hC0DE) begin errors++; $display("FAIL lat3_data rd=%h required c0de", d); end
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_round_robin();
    apply_reset();
    repeat (2) begin
      exp_q.push_back({2'd2, 16'h5A5A});
      exp_q.push_back({2'd3, 16'h1234});
      exp_q.push_back({2'd1, 16'hBEEF});
    end
    fork
      req_drive(ID_F, 1'b0, 16'h0010, 16'h0, 2);
      req_drive(ID_D, 1'b0, 16'h0020, 16'h0, 2);
      req_drive(ID_S, 1'b0, 16'h00FF, 16'h0, 2);
    join
    tick();
    // Leave a known value at 0x0050 for the back-to-back read.
    exp_q.push_back({2'd2, 16'h0000});
    req_drive(ID_D, 1'b1, 16'h0050, 16'hA5A5, 1);
    tick();
  endtask
`else
  task automatic test_collision();
    exp_q.push_back({2'd3, 16'h1234});
    exp_q.push_back({2'd2, 16'h0000});
    exp_q.push_back({2'd1, 16'hBEEF});
    fork
      req_drive(ID_F, 1'b0, 16'h0010, 16'h0, 1);
      req_drive(ID_D, 1'b1, 16'h0050, 16'hA5A5, 1);
      req_drive(ID_S, 1'b0, 16'h00FF, 16'h0, 1);
    join
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    logic [15:0] rnd;
    exp_q.push_back({2'd2, 16'hA5A5});
    req_drive(ID_D, 1'b0, 16'h0050, 16'h0, 1);
    rnd = 16'($urandom_range(1, 16'hFFFF));
    exp_q.push_back({2'd3, 16'h0000});
    req_drive(ID_S, 1'b1, 16'h0060, rnd, 1);
    exp_q.push_back({2'd1, rnd});
    req_drive(ID_F, 1'b0, 16'h0060, 16'h0, 1);
    tick();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h5A5A;
    mem[16'h0030] = 16'h7777;
    mem[16'h0040] = 16'hC0DE;
    mem[16'h0050] = 16'h0000;
    init_bus();
    test_reset();
    test_single_fetch();
    test_push_pop();
    test_field_change();
    test_reset_mid_read();
    test_read_lat3();
`ifdef MEM_ARB_RR_EN
    test_round_robin();
`else
    test_collision();
`endif
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
